// File: rtl/sha3_pad_feed_if.sv
// Message-in / beat-out bus for the SHA3-256 pad feeder.
//   msg_valid/msg_ready : word handshake; a word moves on a rising edge with both high
//   msg_data            : 64-bit little-endian message word
//   msg_last, msg_bytes : final-word marker and its valid byte count (0..8)
//   pushout/doutix/dout : beat valid, beat index and 200-bit beat toward the permutation
// slave  : the feeder side (consumes words, produces beats)
// master : the message source / beat sink side
interface sha3_pad_feed_if #(
  parameter int LANE_W = 64,
  parameter int BEAT_W = 200
) ();
  logic              msg_valid;
  logic              msg_ready;
  logic [LANE_W-1:0] msg_data;
  logic              msg_last;
  logic [3:0]        msg_bytes;
  logic              pushout;
  logic [2:0]        doutix;
  logic [BEAT_W-1:0] dout;

  modport slave (
    input  msg_valid, msg_data, msg_last, msg_bytes,
    output msg_ready, pushout, doutix, dout
  );

  modport master (
    output msg_valid, msg_data, msg_last, msg_bytes,
    input  msg_ready, pushout, doutix, dout
  );
endinterface

// File: rtl/sha3_pad_feed.sv
// SHA3-256 single-block pad feeder.
// Collects a message of 0..135 bytes as 64-bit little-endian words, applies
// the SHA3 domain/pad bytes (0x06 at byte L, 0x80 at byte 135) and streams the
// 1600-bit state to the Keccak pipeline as 8 registered beats of 200 bits.
// Messages of 136 bytes or more raise a one-cycle err_len and are dropped.
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low reset
//   bus     : sha3_pad_feed_if.slave (message handshake in, beats out)
//   busy    : high whenever the FSM is not in IDLE
//   err_len : one-cycle pulse when a message is too long
module sha3_pad_feed #(
  parameter int LANE_W     = 64,
  parameter int RATE_LANES = 17,
  parameter int BEAT_W     = 200,
  parameter int NBEATS     = 8
) (
  input  logic             clk,
  input  logic             reset,
  sha3_pad_feed_if.slave   bus,
  output logic             busy,
  output logic             err_len
);

  localparam int STATE_W    = NBEATS * BEAT_W;
  localparam int RATE_W     = RATE_LANES * LANE_W;
  localparam int RATE_BYTES = RATE_W / 8;
  localparam int LAST_BYTE  = RATE_BYTES - 1;
  localparam int WORD_BYTES = LANE_W / 8;
  localparam int IX_W       = $clog2(NBEATS);
  localparam int WCNT_W     = $clog2(RATE_LANES);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, PAD, EMIT} state_t;

  state_t              state, state_nxt;
  logic [RATE_W-1:0]   rate_buf;
  logic [WCNT_W-1:0]   wcnt;
  logic [7:0]          len_q;
  logic                pushout_q;
  logic [IX_W-1:0]     doutix_q;
  logic [BEAT_W-1:0]   dout_q;

  logic                msg_ready_int;
  logic                accept;
  logic [3:0]          bytes_eff;
  logic [7:0]          msg_len;
  logic                too_long;
  logic [RATE_W-1:0]   padded;

  // Keep the first n bytes of a word, zero the rest.
  function automatic logic [LANE_W-1:0] mask_bytes(input logic [LANE_W-1:0] w,
                                                   input logic [3:0]        n);
    logic [LANE_W-1:0] m;
    m = '0;
    for (int k = 0; k < WORD_BYTES; k++)
      if (k < int'(n)) m[8*k +: 8] = w[8*k +: 8];
    return m;
  endfunction

  // SHA3 padding inside the rate; len is at most LAST_BYTE so both bytes exist.
  function automatic logic [RATE_W-1:0] apply_pad(input logic [RATE_W-1:0] r,
                                                  input logic [7:0]        len);
    logic [RATE_W-1:0] p;
    p = r;
    p[8*int'(len) +: 8]  = p[8*int'(len) +: 8] ^ 8'h06;
    p[8*LAST_BYTE +: 8]  = p[8*LAST_BYTE +: 8] ^ 8'h80;
    return p;
  endfunction

  // Beat ix of the full state; capacity lanes above the rate are zero.
  function automatic logic [BEAT_W-1:0] beat_slice(input logic [RATE_W-1:0] r,
                                                   input logic [IX_W-1:0]   ix);
    logic [STATE_W-1:0] st;
    st = {{(STATE_W-RATE_W){1'b0}}, r};
    return st[BEAT_W*int'(ix) +: BEAT_W];
  endfunction

  assign msg_ready_int = reset && ((state == IDLE) || (state == FILL) || (state == DRAIN));
  assign accept        = bus.msg_valid && msg_ready_int;
  assign bytes_eff     = (bus.msg_bytes > 4'(WORD_BYTES)) ? 4'(WORD_BYTES) : bus.msg_bytes;
  assign msg_len       = {wcnt, 3'b000} + {4'b0000, bytes_eff};
  // A last word may end at byte 135 at most; a non-last word in lane 16 means
  // at least 136 bytes are coming.
  assign too_long      = bus.msg_last ? (msg_len > 8'(LAST_BYTE))
                                      : (wcnt == WCNT_W'(RATE_LANES-1));
  assign padded        = apply_pad(rate_buf, len_q);

  assign bus.msg_ready = msg_ready_int;
  assign bus.pushout   = pushout_q;
  assign bus.doutix    = doutix_q;
  assign bus.dout      = dout_q;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FILL: begin
        if (accept) begin
          if (too_long)          state_nxt = bus.msg_last ? IDLE : DRAIN;
          else if (bus.msg_last) state_nxt = PAD;
          else                   state_nxt = FILL;
        end
      end
      DRAIN:   if (accept && bus.msg_last) state_nxt = IDLE;
      PAD:     state_nxt = EMIT;
      EMIT:    if (doutix_q == IX_W'(NBEATS-1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Word capture / pad / beat output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_buf  <= '0;
      wcnt      <= '0;
      len_q     <= '0;
      pushout_q <= 1'b0;
      doutix_q  <= '0;
      dout_q    <= '0;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            if (too_long) begin
              err_len  <= 1'b1;
              rate_buf <= '0;
              wcnt     <= '0;
            end else begin
              rate_buf[LANE_W*int'(wcnt) +: LANE_W] <=
                bus.msg_last ? mask_bytes(bus.msg_data, bytes_eff) : bus.msg_data;
              wcnt <= wcnt + WCNT_W'(1);
              if (bus.msg_last) len_q <= msg_len;
            end
          end
        end
        // Beat 0 leaves with the padded state so the beats follow PAD directly.
        PAD: begin
          rate_buf  <= padded;
          pushout_q <= 1'b1;
          doutix_q  <= '0;
          dout_q    <= beat_slice(padded, '0);
        end
        EMIT: begin
          if (doutix_q == IX_W'(NBEATS-1)) begin
            pushout_q <= 1'b0;
            doutix_q  <= '0;
            dout_q    <= '0;
            rate_buf  <= '0;
            wcnt      <= '0;
          end else begin
            doutix_q <= doutix_q + IX_W'(1);
            dout_q   <= beat_slice(rate_buf, doutix_q + IX_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule
